// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce_edge input-conditioning block.
package debounce_pkg;

   typedef enum logic [1:0] {
      ST_LOW   = 2'd0,
      CHK_HIGH = 2'd1,
      ST_HIGH  = 2'd2,
      CHK_LOW  = 2'd3
   } deb_state_t;

   localparam int SYNC_MIN = 2;
   localparam int SYNC_MAX = 4;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level; every stage clears on rst.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;
   logic [STAGES-1:0] chain_d;

   always_comb begin
      chain_d = {chain_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain_q <= '0;
      end else begin
         chain_q <= chain_d;
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronizes and debounces a raw level, producing a clean level plus rise/fall pulses.
// Optional accepted-rise counter enabled by defining DEBOUNCE_EDGE_EVT_CNT_EN.
module debounce_edge
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int EVT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   output logic             q,
   output logic             rise,
   output logic             fall,
   output logic [EVT_W-1:0] evt_cnt
);

   localparam int              CNT_W    = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("debounce_edge: SYNC_STAGES out of range");
   end
   if (STABLE_CYCLES < 2) begin : g_bad_stable
      $error("debounce_edge: STABLE_CYCLES must be at least 2");
   end

   logic s;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (s)
   );

   deb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_q, q_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   // A single opposite sample in a CHK state drops straight back; no partial credit survives.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         ST_LOW: begin
            if (s) begin
               state_d = CHK_HIGH;
               cnt_d   = CNT_ONE;
            end
         end
         CHK_HIGH: begin
            if (!s) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_d = CHK_LOW;
               cnt_d   = CNT_ONE;
            end
         end
         CHK_LOW: begin
            if (s) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               cnt_d   = '0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
         end
      endcase
      q_d = (state_d == ST_HIGH) || (state_d == CHK_LOW);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
         q_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign q    = q_q;
   assign rise = rise_q;
   assign fall = fall_q;

`ifdef DEBOUNCE_EDGE_EVT_CNT_EN
   logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

   // Counts on the same edge that raises rise, so evt_cnt and rise change together.
   always_comb begin
      evt_cnt_d = evt_cnt_q;
      if (rise_d) begin
         evt_cnt_d = evt_cnt_q + EVT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_cnt_q <= '0;
      end else begin
         evt_cnt_q <= evt_cnt_d;
      end
   end

   assign evt_cnt = evt_cnt_q;
`else
   assign evt_cnt = '0;
`endif

endmodule

// File: doc/debounce_edge.md
# debounce_edge

Input-conditioning stage that turns a raw, asynchronous, bouncy level (push-button, switch, external strobe) into a clean, clock-synchronous level plus single-cycle rise/fall pulses. It sits directly upstream of the team's async-reset D flip-flop and register stages: its outputs are what those flops sample as `d`, so downstream logic never sees metastable or chattering inputs.

## Interface
- `SYNC_STAGES`, 2, number of synchronizer flops on `din`; legal range 2–4.
- `STABLE_CYCLES`, 4, consecutive identical synchronized samples required to accept a new level; must be ≥ 2.
- `EVT_W`, 8, width of the optional event counter.
- `clk` input 1: clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high; clears every flop immediately.
- `din` input 1: raw asynchronous input level.
- `q` output 1: debounced level, registered.
- `rise` output 1: one-cycle pulse when `q` goes 0→1, registered.
- `fall` output 1: one-cycle pulse when `q` goes 1→0, registered.
- `evt_cnt` output EVT_W: count of accepted rising edges. Tied to 0 unless `DEBOUNCE_EDGE_EVT_CNT_EN` is defined.

## Operation
- `din` passes through a SYNC_STAGES-deep flop chain, all reset to 0; the last stage is `s`.
- FSM states: ST_LOW, CHK_HIGH, ST_HIGH, CHK_LOW. Counter `cnt` has width $clog2(STABLE_CYCLES+1).
- ST_LOW: if `s`=1, go to CHK_HIGH and set `cnt`=1. Otherwise hold.
- CHK_HIGH: if `s`=0, return to ST_LOW and set `cnt`=0 (bounce rejected). Else if `cnt`==STABLE_CYCLES-1, go to ST_HIGH, set `q`=1, pulse `rise`, clear `cnt`. Else increment `cnt`.
- ST_HIGH and CHK_LOW mirror these rules with polarity inverted; acceptance sets `q`=0 and pulses `fall`.
- `q` is 1 only in ST_HIGH and CHK_LOW. `rise` and `fall` are never high together and never high for two consecutive cycles.
- Any opposite sample during a CHK state restarts qualification from scratch. No partial credit is kept.

## Timing
- Reset values: `q`=0, `rise`=0, `fall`=0, `evt_cnt`=0, state=ST_LOW, `cnt`=0, sync chain=0.
- Latency: `din` is first captured at edge k and then held. `q`, `rise`/`fall` update after edge k+SYNC_STAGES+STABLE_CYCLES-1.
- Pulse width is exactly 1 clk. A pulse is asserted in the same cycle `q` changes.
- Glitches shorter than STABLE_CYCLES clk, measured at `s`, produce no output change.
- Reset mid-qualification aborts it. With `din` held high through release, a full qualification follows and `rise` fires once.
- Reset asserted in the same cycle as a pulse clears the pulse immediately.

## Configuration
- `DEBOUNCE_EDGE_EVT_CNT_EN` defined: `evt_cnt` increments by 1 in each cycle `rise`=1, and wraps from 2^EVT_W-1 to 0.
- Not defined: the counter logic is removed and `evt_cnt` is constant 0. All other behaviour is identical.

## Structure
- Package `debounce_pkg` holds:
  - the state enum `deb_state_t` (ST_LOW, CHK_HIGH, ST_HIGH, CHK_LOW);
  - the limits `SYNC_MIN`=2 and `SYNC_MAX`=4.
- Sub-module `sync_chain` (parameter STAGES; ports `clk`, `rst`, `d`, `q`) implements the synchronizer. The FSM, counter and pulse logic stay in `debounce_edge`.

## Test plan
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=4 and a 10 ns clk.
- Clean step: `din` 0→1 before edge 1, then held. `q`=1 and `rise`=1 after edge 6; `rise`=0 after edge 7; `fall` stays 0.
- Bounce rejection: `din` pulses high for 2 cycles, low for 1, then high and held. Exactly one `rise`, 4 cycles after the final stable `s`=1. No `fall`.
- Release: from `q`=1, `din` 1→0 and held. `q`=0 and `fall`=1 exactly 6 edges after first capture; one pulse only.
- Async reset mid-check: assert `rst` for 3 ns while in CHK_HIGH with `cnt`=2. `q`, state and `cnt` clear without waiting for a clock edge. With `din` still 1, `rise` fires 6 edges after release.
- Event counter (macro defined, EVT_W=3): 9 clean press/release cycles. `evt_cnt` reads 1..7, 0, 1.
- Macro undefined: same stimulus as the event-counter case. `evt_cnt`=0 throughout; `q`, `rise` and `fall` match the macro-defined run cycle for cycle.
